// File: rtl/mix_columns_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_engine_pkg
// Description : Shared GF(2^8) helpers and constants for the AES column mixer.
//               Holds the state/column widths, the forward and inverse
//               MixColumns coefficient rows, the engine FSM encoding, and the
//               xtime / gf_mul functions. The field is reduced mod 0x11B.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mix_columns_engine_pkg;

    localparam int STATE_W  = 128;
    localparam int COL_W    = 32;
    localparam int NUM_COLS = STATE_W / COL_W;

    // First row of each matrix; row r is this row rotated right by r.
    localparam logic [7:0] c_FWD_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] c_INV_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply. Called only with constant coefficients, so it
    // folds down to a few xtime stages and XORs.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_columns_engine_mix_column_unit.sv
`default_nettype none
// ============================================================================
// Module      : mix_column_unit
// Description : Purely combinational MixColumns / InvMixColumns on a single
//               32-bit column. Byte 0 of the column sits in bits [31:24].
// Ports       : i_col  in  32  column to mix
//               i_inv   in   1  1 = InvMixColumns, 0 = MixColumns
//               o_col  out  32  mixed column, same byte order as i_col
// Revision    : 1.0 - initial release
// ============================================================================
module mix_column_unit
    import mix_columns_engine_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    input  logic             i_inv,
    output logic [COL_W-1:0] o_col
);

    logic [7:0] w_a [4];
    logic [7:0] w_o [4];

    assign w_a[0] = i_col[31:24];
    assign w_a[1] = i_col[23:16];
    assign w_a[2] = i_col[15:8];
    assign w_a[3] = i_col[7:0];

    // Output byte r = XOR over j of coef[j] * a[(r+j) mod 4]; both directions
    // are built from constant multiplies and the mode picks one.
    always_comb begin
        logic [7:0] v_f;
        logic [7:0] v_i;
        for (int r = 0; r < 4; r++) begin
            v_f = '0;
            v_i = '0;
            for (int j = 0; j < 4; j++) begin
                v_f = v_f ^ gf_mul(w_a[2'(r + j)], c_FWD_COEF[2'(j)]);
                v_i = v_i ^ gf_mul(w_a[2'(r + j)], c_INV_COEF[2'(j)]);
            end
            w_o[r] = i_inv ? v_i : v_f;
        end
    end

    assign o_col = {w_o[0], w_o[1], w_o[2], w_o[3]};

endmodule
`default_nettype wire

// File: rtl/mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_engine
// Description : Multi-cycle AES MixColumns / InvMixColumns engine on one
//               128-bit state, COLS_PER_CYCLE columns per clock, with
//               valid/ready handshakes on both sides.
//               Byte b of the state occupies bits [127-8b -: 8], i.e. byte 0
//               is the most significant byte; column c is bytes 4c..4c+3.
// Ports       : clk        in    1  clock, rising edge
//               rst_n      in    1  asynchronous active-low reset
//               in_valid   in    1  in_data / in_inv valid
//               in_ready  out    1  engine can accept a block
//               in_data    in  128  input state
//               in_inv     in    1  1 = InvMixColumns, 0 = MixColumns
//               out_valid out    1  out_data holds a finished block
//               out_ready  in    1  downstream accepts out_data
//               out_data  out  128  mixed state
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_engine
    import mix_columns_engine_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,   // 1, 2 or 4
    parameter bit SUPPORT_FWD    = 1'b1 // 0: inverse-only, in_inv ignored
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data
);

    localparam int         N_CYC  = NUM_COLS / COLS_PER_CYCLE;
    localparam logic [1:0] c_LAST = 2'(N_CYC - 1);

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic             r_inv;
    logic             r_out_valid;
    logic [COL_W-1:0] r_src [NUM_COLS];
    logic [COL_W-1:0] r_res [NUM_COLS];

    logic [1:0]          w_idx     [COLS_PER_CYCLE];
    logic [COL_W-1:0]    w_col_in  [COLS_PER_CYCLE];
    logic [COL_W-1:0]    w_col_out [COLS_PER_CYCLE];
    logic [NUM_COLS-1:0] w_hit;
    logic [COL_W-1:0]    w_next    [NUM_COLS];
    logic                w_accept;

    // Combinational so a block can be accepted in the same cycle the
    // previous one retires.
    assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;

    // Unit k works on column cnt*CPC + k. For CPC=4 the cast multiplier is 0
    // and cnt never leaves 0, so the index reduces to k.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
        assign w_idx[k]    = r_cnt * 2'(COLS_PER_CYCLE) + 2'(k);
        assign w_col_in[k] = r_src[w_idx[k]];

        mix_column_unit u_mix (
            .i_col (w_col_in[k]),
            .i_inv (r_inv),
            .o_col (w_col_out[k])
        );
    end

    // Column c is produced by unit (c mod CPC) on counter value c / CPC.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int         K    = c % COLS_PER_CYCLE;
        localparam logic [1:0] SLOT = 2'(c / COLS_PER_CYCLE);

        assign w_hit[c]  = (r_cnt == SLOT);
        assign w_next[c] = w_col_out[K];
        assign out_data[STATE_W-1-COL_W*c -: COL_W] = r_res[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_inv       <= 1'b0;
            r_out_valid <= 1'b0;
            for (int c = 0; c < NUM_COLS; c++) begin
                r_src[c] <= '0;
                r_res[c] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (w_hit[c]) begin
                            r_res[c] <= w_next[c];
                        end
                    end
                    if (r_cnt == c_LAST) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= w_accept ? ST_BUSY : ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase

            // w_accept is only possible in IDLE or a retiring DONE, so the
            // capture can sit outside the state decode.
            if (w_accept) begin
                r_inv <= SUPPORT_FWD ? in_inv : 1'b1;
                for (int c = 0; c < NUM_COLS; c++) begin
                    r_src[c] <= in_data[STATE_W-1-COL_W*c -: COL_W];
                end
            end
        end
    end

endmodule
`default_nettype wire
